// File: rtl/sr_latch_driver.sv
// Clocked S/R pulse generator for a NOR SR latch with Q feedback check.
// Optional SR_RETRY_EN: re-drive the pulse once after the first timeout.
module sr_latch_driver #(
  parameter int PULSE_W = 2,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  input  logic err_clr,
  input  logic q_fb,
  output logic S,
  output logic R,
  output logic busy,
  output logic done,
  output logic err,
  output logic conflict
);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    WAIT,
    ERR
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             target, target_n;
  logic             q_fb_r;
  logic             s_n, r_n, done_n, err_n, conflict_n;
`ifdef SR_RETRY_EN
  logic             retry, retry_n;
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    target_n   = target;
    s_n        = 1'b0;
    r_n        = 1'b0;
    done_n     = 1'b0;
    err_n      = err;
    conflict_n = 1'b0;
`ifdef SR_RETRY_EN
    retry_n    = retry;
`endif
    unique case (state)
      IDLE: begin
`ifdef SR_RETRY_EN
        retry_n = 1'b0;
`endif
        if (set_req && clr_req) begin
          conflict_n = 1'b1;
        end else if (set_req ^ clr_req) begin
          target_n = set_req;
          if (q_fb_r == set_req) begin
            done_n = 1'b1;
          end else begin
            state_n = PULSE;
            cnt_n   = '0;
            s_n     = set_req;
            r_n     = clr_req;
          end
        end
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_n = WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
          s_n   = target;
          r_n   = !target;
        end
      end
      WAIT: begin
        if (q_fb_r == target) begin
          done_n  = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == WAIT_LAST) begin
          cnt_n = '0;
`ifdef SR_RETRY_EN
          if (!retry) begin
            retry_n = 1'b1;
            state_n = PULSE;
            s_n     = target;
            r_n     = !target;
          end else begin
            state_n = ERR;
            err_n   = 1'b1;
          end
`else
          state_n = ERR;
          err_n   = 1'b1;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ERR: begin
        if (err_clr) begin
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      target   <= 1'b0;
      q_fb_r   <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      conflict <= 1'b0;
`ifdef SR_RETRY_EN
      retry    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      target   <= target_n;
      q_fb_r   <= q_fb;
      S        <= s_n;
      R        <= r_n;
      busy     <= (state_n != IDLE);
      done     <= done_n;
      err      <= err_n;
      conflict <= conflict_n;
`ifdef SR_RETRY_EN
      retry    <= retry_n;
`endif
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: directed steps, event scoreboard, NOR latch model.
module tb_sr_latch_driver;

  localparam int KDONE = 1;
  localparam int KCONF = 2;
  localparam int KERR  = 3;
`ifdef SR_RETRY_EN
  localparam int ERRD = 12;
`else
  localparam int ERRD = 6;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_req = 1'b0;
  logic clr_req = 1'b0;
  logic err_clr = 1'b0;
  logic tie0 = 1'b0;
  logic q_lat = 1'b0;
  logic q_fb;
  logic S, R, busy, done, err, conflict;
  logic err_q = 1'b0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  sr_latch_driver #(
    .PULSE_W(2),
    .TIMEOUT(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .set_req(set_req),
    .clr_req(clr_req),
    .err_clr(err_clr),
    .q_fb(q_fb),
    .S(S),
    .R(R),
    .busy(busy),
    .done(done),
    .err(err),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural NOR latch driven by the DUT
  always_latch begin
    if (S && !R) q_lat <= 1'b1;
    else if (R && !S) q_lat <= 1'b0;
  end

  assign q_fb = tie0 ? 1'b0 : q_lat;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input int kind, input int due);
    sb.push_back((kind << 24) | due);
  endfunction

  task automatic sb_pop(input int kind);
    logic [31:0] exp;
    exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
    chk("sb_event", (kind << 24) | cyc, exp);
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("s_and_r", {31'b0, S & R}, 32'h0);
      if (done) sb_pop(KDONE);
      if (conflict) sb_pop(KCONF);
      if (err && !err_q) sb_pop(KERR);
      err_q <= err;
    end
  end

  initial begin
    int e;
    int free_at;
    logic mq, s, c, exp_s;

    // 1: reset, then basic set
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_outs", {S, R, busy, done, err, conflict}, 6'b0);
    rst_n = 1'b1;
    tick();
    tick();
    set_req = 1'b1;
    push(KDONE, cyc + 4);
    tick();
    set_req = 1'b0;
    chk("t1_s_on", {S, R, busy}, 3'b101);
    tick();
    chk("t1_s_hold", {S, R, busy}, 3'b101);
    tick();
    chk("t1_wait", {S, R, busy, done}, 4'b0010);
    tick();
    chk("t1_done", {busy, done, q_lat}, 3'b011);
    tick();
    chk("t1_done_once", {busy, done}, 2'b00);

    // 2: clear after set, then clear with Q already 0
    clr_req = 1'b1;
    push(KDONE, cyc + 4);
    tick();
    clr_req = 1'b0;
    chk("t2_r_on", {S, R, busy}, 3'b011);
    tick();
    chk("t2_r_hold", {S, R, busy}, 3'b011);
    tick();
    chk("t2_wait", {S, R, busy}, 3'b001);
    tick();
    chk("t2_done", {busy, done, q_lat}, 3'b010);
    tick();
    clr_req = 1'b1;
    push(KDONE, cyc + 1);
    tick();
    clr_req = 1'b0;
    chk("t2_fast_done", {S, R, busy, done}, 4'b0001);
    tick();
    chk("t2_fast_idle", {R, busy, done}, 3'b000);

    // 3: conflict
    set_req = 1'b1;
    clr_req = 1'b1;
    push(KCONF, cyc + 1);
    tick();
    set_req = 1'b0;
    clr_req = 1'b0;
    chk("t3_conflict", {S, R, busy, done, conflict}, 5'b00001);
    tick();
    chk("t3_after", {conflict, q_lat}, 2'b00);

    // 4: timeout with Q stuck at 0
    tie0 = 1'b1;
    tick();
    set_req = 1'b1;
    push(KERR, cyc + 1 + ERRD);
    tick();
    set_req = 1'b0;
    chk("t4_s0", {S, R, busy, err}, 4'b1010);
    for (int k = 1; k <= ERRD; k++) begin
      tick();
      exp_s = (k == 1) || (ERRD == 12 && (k == 6 || k == 7));
      chk("t4_seq", {k[7:0], S, R, busy, err},
          {k[7:0], exp_s, 1'b0, 1'b1, (k == ERRD)});
    end
    set_req = 1'b1;
    tick();
    set_req = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("t4_err_hold", {S, R, busy, err}, 4'b0011);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr", {busy, err}, 2'b00);
    tie0 = 1'b0;
    tick();
    tick();

    // 5: reset during the first S cycle
    clr_req = 1'b1;
    push(KDONE, cyc + 4);
    tick();
    clr_req = 1'b0;
    chk("t5_r_on", {S, R}, 2'b01);
    tick();
    tick();
    tick();
    chk("t5_cleared", {done, q_lat}, 2'b10);
    tick();
    set_req = 1'b1;
    tick();
    set_req = 1'b0;
    chk("t5_s_on", {S, R, busy}, 3'b101);
    rst_n = 1'b0;
    tick();
    chk("t5_rst", {S, R, busy, done, err, conflict}, 6'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_quiet", {S, R, busy, done}, 4'b0);
    end

    // 6: random requests every cycle
    tick();
    mq = q_lat;
    free_at = 0;
    for (int i = 0; i < 200; i++) begin
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      set_req = s;
      clr_req = c;
      e = cyc + 1;
      if (e >= free_at) begin
        if (s && c) begin
          push(KCONF, e);
          free_at = e + 1;
        end else if (s != c) begin
          if (s == mq) begin
            push(KDONE, e);
            free_at = e + 1;
          end else begin
            push(KDONE, e + 3);
            free_at = e + 4;
            mq = s;
          end
        end
      end
      tick();
    end
    set_req = 1'b0;
    clr_req = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("sb_empty", sb.size(), 0);
    chk("t6_q", {31'b0, q_lat}, {31'b0, mq});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
